// File: rtl/vjtag_resp_pkg.sv
// vjtag_resp_pkg: virtual IR codes and ir_out status bit positions
// shared by the virtual JTAG DR responder and its bench.
package vjtag_resp_pkg;

   localparam int IR_BYPASS = 0;
   localparam int IR_IDCODE = 1;
   localparam int IR_WRITE  = 2;
   localparam int IR_READ   = 3;
   localparam int IR_CLEAR  = 4;

   localparam int ST_HOLD_FULL  = 0;
   localparam int ST_WR_VALID   = 1;
   localparam int ST_OVERFLOW   = 2;
   localparam int ST_PARITY_ERR = 3;

endpackage

// File: rtl/vjtag_dr_responder_if.sv
// vjtag_dr_responder_if: fabric-side write/read valid/ready bundle.
// master = responder (drives wr_*, rd_ready); slave = fabric logic.
interface vjtag_dr_responder_if #(
   parameter int DR_W = 32
);
   logic            wr_valid;
   logic            wr_ready;
   logic [DR_W-1:0] wr_data;
   logic            rd_valid;
   logic            rd_ready;
   logic [DR_W-1:0] rd_data;

   modport master (
      output wr_valid, wr_data, rd_ready,
      input  wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  wr_valid, wr_data, rd_ready,
      output wr_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/vjtag_sync_edge.sv
// vjtag_sync_edge: 2-flop synchronizers into clk. tck gets a third
// flop for rise/fall detect; level inputs use the plain 2-flop path.
// Ports: clk, rst_n, tck, lvl[W] in; lvl_s[W], rise, fall out.
module vjtag_sync_edge #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tck,
   input  logic [W-1:0] lvl,
   output logic [W-1:0] lvl_s,
   output logic         rise,
   output logic         fall
);
   logic         tck_m, tck_s, tck_q;
   logic [W-1:0] lvl_m;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tck_m <= 1'b0;
         tck_s <= 1'b0;
         tck_q <= 1'b0;
         lvl_m <= '0;
         lvl_s <= '0;
      end else begin
         tck_m <= tck;
         tck_s <= tck_m;
         tck_q <= tck_s;
         lvl_m <= lvl;
         lvl_s <= lvl_m;
      end
   end

   assign rise = tck_s & ~tck_q;
   assign fall = ~tck_s & tck_q;
endmodule

// File: rtl/vjtag_dr_responder.sv
// vjtag_dr_responder: virtual JTAG user node; decodes IR, shifts DR
// and bridges scans to the bus write/read handshakes. Optional
// macro VJTAG_RESP_PARITY_EN adds an even-parity bit to the DR.
// Ports: clk, rst_n, tck, tdi, virtual_state_{cdr,sdr,udr,uir},
// ir_in in; tdo, ir_out out; bus = vjtag_dr_responder_if.master.
module vjtag_dr_responder
   import vjtag_resp_pkg::*;
#(
   parameter int          IR_W   = 4,
   parameter int          DR_W   = 32,
   parameter logic [31:0] IDCODE = 32'h0A5E0001
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tck,
   input  logic            tdi,
   input  logic            virtual_state_cdr,
   input  logic            virtual_state_sdr,
   input  logic            virtual_state_udr,
   input  logic            virtual_state_uir,
   input  logic [IR_W-1:0] ir_in,
   output logic            tdo,
   output logic [IR_W-1:0] ir_out,
   vjtag_dr_responder_if.master bus
);
`ifdef VJTAG_RESP_PARITY_EN
   localparam int SR_W = DR_W + 1;
`else
   localparam int SR_W = DR_W;
`endif
   localparam logic [DR_W-1:0] ID_V = DR_W'(IDCODE);

   function automatic logic [SR_W-1:0] with_par(
      input logic [DR_W-1:0] d
   );
`ifdef VJTAG_RESP_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   logic            rise, fall;
   logic            tdi_s, cdr_s, sdr_s, udr_s, uir_s;
   logic [IR_W-1:0] ir_in_s;

   vjtag_sync_edge #(.W(5 + IR_W)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .tck   (tck),
      .lvl   ({tdi, virtual_state_cdr, virtual_state_sdr,
               virtual_state_udr, virtual_state_uir, ir_in}),
      .lvl_s ({tdi_s, cdr_s, sdr_s, udr_s, uir_s, ir_in_s}),
      .rise  (rise),
      .fall  (fall)
   );

   logic [IR_W-1:0] ir_q;
   logic [SR_W-1:0] sr;
   logic [DR_W-1:0] hold, wr_data_q;
   logic            hold_full, wr_valid_q;
   logic            overflow, parity_err, tdo_q;
   logic            is_id, is_wr, is_rd, is_byp, par_ok;

   assign is_id  = (ir_q == IR_W'(IR_IDCODE));
   assign is_wr  = (ir_q == IR_W'(IR_WRITE));
   assign is_rd  = (ir_q == IR_W'(IR_READ));
   assign is_byp = ~(is_id | is_wr | is_rd);

`ifdef VJTAG_RESP_PARITY_EN
   assign par_ok = ~(^sr);
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q       <= IR_W'(IR_BYPASS);
         sr         <= '0;
         hold       <= '0;
         hold_full  <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_data_q  <= '0;
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         tdo_q      <= 1'b0;
      end else begin
         if (wr_valid_q && bus.wr_ready)
            wr_valid_q <= 1'b0;
         if (rise && cdr_s) begin
            unique case (1'b1)
               is_id: sr <= with_par(ID_V);
               is_rd: begin
                  sr        <= hold_full ? with_par(hold) : '0;
                  hold_full <= 1'b0;
               end
               default: sr <= '0;
            endcase
         end
         if (rise && sdr_s) begin
            if (is_byp)
               sr[0] <= tdi_s;
            else
               sr <= {tdi_s, sr[SR_W-1:1]};
         end
         if (fall)
            tdo_q <= sr[0];
         // clear first so a same-clk set below wins
         if (rise && uir_s) begin
            ir_q <= ir_in_s;
            if (ir_in_s == IR_W'(IR_CLEAR)) begin
               overflow   <= 1'b0;
               parity_err <= 1'b0;
            end
         end
         // a word acked this clk frees the slot for the new one
         if (rise && udr_s && is_wr) begin
            if (!par_ok)
               parity_err <= 1'b1;
            else if (wr_valid_q && !bus.wr_ready)
               overflow <= 1'b1;
            else begin
               wr_valid_q <= 1'b1;
               wr_data_q  <= sr[DR_W-1:0];
            end
         end
         // load after the capture clear so the load wins
         if (bus.rd_valid && !hold_full) begin
            hold      <= bus.rd_data;
            hold_full <= 1'b1;
         end
      end
   end

   always_comb begin
      ir_out                = '0;
      ir_out[ST_HOLD_FULL]  = hold_full;
      ir_out[ST_WR_VALID]   = wr_valid_q;
      ir_out[ST_OVERFLOW]   = overflow;
      ir_out[ST_PARITY_ERR] = parity_err;
   end

   assign tdo          = tdo_q;
   assign bus.wr_valid = wr_valid_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.rd_ready = ~hold_full;
endmodule

// File: tb/tb_vjtag_dr_responder.sv
// tb_vjtag_dr_responder: directed plus random scans of the virtual
// JTAG DR responder against a transaction-level model.
module tb_vjtag_dr_responder;
   import vjtag_resp_pkg::*;

   localparam int IR_W = 4;
   localparam int DR_W = 32;
`ifdef VJTAG_RESP_PARITY_EN
   localparam int SR_W = DR_W + 1;
`else
   localparam int SR_W = DR_W;
`endif
   localparam logic [31:0] ID = 32'h0A5E0001;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            tck = 1'b0;
   logic            tdi = 1'b0;
   logic            cdr = 1'b0, sdr = 1'b0;
   logic            udr = 1'b0, uir = 1'b0;
   logic [IR_W-1:0] ir_in = '0;
   logic [IR_W-1:0] ir_out;
   logic            tdo;

   vjtag_dr_responder_if #(.DR_W(DR_W)) bus ();

   vjtag_dr_responder #(
      .IR_W(IR_W), .DR_W(DR_W), .IDCODE(ID)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .tck               (tck),
      .tdi               (tdi),
      .virtual_state_cdr (cdr),
      .virtual_state_sdr (sdr),
      .virtual_state_udr (udr),
      .virtual_state_uir (uir),
      .ir_in             (ir_in),
      .tdo               (tdo),
      .ir_out            (ir_out),
      .bus               (bus)
   );

   always #5 clk = ~clk;

   int n_chk, n_fail;

   // transaction-level model state
   logic        m_hold_full, m_pend, m_ovf, m_perr;
   logic [31:0] m_hold, m_wdata;
   logic [SR_W-1:0] dout;

   function automatic logic [SR_W-1:0] tb_par(input logic [31:0] d);
`ifdef VJTAG_RESP_PARITY_EN
      logic p;
      p = ($countones(d) % 2) == 1;
      return {p, d};
`else
      return d;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag);
      chk(tag, 64'(ir_out),
          64'({m_perr, m_ovf, m_pend, m_hold_full}));
   endtask

   // one tck period (8 clk); tdo sampled just before the rise
   task automatic tck_cycle(input logic c, s, u, i, d,
                            output logic o);
      cdr = c; sdr = s; udr = u; uir = i; tdi = d;
      #40;
      o = tdo;
      tck = 1'b1;
      #40;
      tck = 1'b0;
   endtask

   task automatic ir_scan(input int code);
      logic o;
      ir_in = IR_W'(code);
      tck_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, o);
      if (code == IR_CLEAR) begin
         m_ovf  = 1'b0;
         m_perr = 1'b0;
      end
   endtask

   task automatic dr_scan(input logic [SR_W-1:0] din, input int n,
                          input bit upd,
                          output logic [SR_W-1:0] q);
      logic o;
      tck_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o);
      q = '0;
      for (int k = 0; k < n; k++) begin
         tck_cycle(1'b0, 1'b1, 1'b0, 1'b0, din[k], o);
         q[k] = o;
      end
      if (upd)
         tck_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, o);
      else
         tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o);
   endtask

   task automatic do_write(input logic [31:0] d);
      ir_scan(IR_WRITE);
      dr_scan(tb_par(d), SR_W, 1'b1, dout);
      chk("wr_capture", 64'(dout), 64'(0));
      if (m_pend)
         m_ovf = 1'b1;
      else begin
         m_pend  = 1'b1;
         m_wdata = d;
      end
      chk("wr_valid", 64'(bus.wr_valid), 64'(m_pend));
      chk("wr_data", 64'(bus.wr_data), 64'(m_wdata));
      chk_status("wr_status");
   endtask

   task automatic do_ack();
      @(negedge clk) bus.wr_ready = 1'b1;
      @(negedge clk) bus.wr_ready = 1'b0;
      m_pend = 1'b0;
      chk("ack_wr_valid", 64'(bus.wr_valid), 64'(0));
   endtask

   task automatic do_load(input logic [31:0] d);
      @(negedge clk);
      bus.rd_valid = 1'b1;
      bus.rd_data  = d;
      @(negedge clk) bus.rd_valid = 1'b0;
      if (!m_hold_full) begin
         m_hold      = d;
         m_hold_full = 1'b1;
      end
      chk("rd_ready_load", 64'(bus.rd_ready), 64'(!m_hold_full));
      chk_status("load_status");
   endtask

   task automatic do_read_scan();
      logic [SR_W-1:0] e;
      ir_scan(IR_READ);
      dr_scan('0, SR_W, 1'b0, dout);
      e = m_hold_full ? tb_par(m_hold) : '0;
      m_hold_full = 1'b0;
      chk("rd_shift", 64'(dout), 64'(e));
      chk("rd_ready_scan", 64'(bus.rd_ready), 64'(1));
   endtask

   task automatic do_idcode();
      ir_scan(IR_IDCODE);
      dr_scan('0, SR_W, 1'b0, dout);
      chk("idcode", 64'(dout), 64'(tb_par(ID)));
   endtask

   // one-bit path: bit k comes back one tck later, after a 0
   task automatic do_bypass(input logic [7:0] pat);
      logic [SR_W-1:0] din;
      din = SR_W'(pat);
      ir_scan(IR_BYPASS);
      dr_scan(din, 9, 1'b0, dout);
      chk("bypass", 64'(dout[8:0]), 64'({pat, 1'b0}));
   endtask

   initial begin
      logic o;
      n_chk = 0;
      n_fail = 0;
      m_hold_full = 1'b0; m_pend = 1'b0;
      m_ovf = 1'b0; m_perr = 1'b0;
      m_hold = '0; m_wdata = '0;
      bus.wr_ready = 1'b0;
      bus.rd_valid = 1'b0;
      bus.rd_data  = '0;

      repeat (3) @(negedge clk);
      chk("rst_tdo", 64'(tdo), 64'(0));
      chk("rst_ir_out", 64'(ir_out), 64'(0));
      chk("rst_wr_valid", 64'(bus.wr_valid), 64'(0));
      chk("rst_wr_data", 64'(bus.wr_data), 64'(0));
      chk("rst_rd_ready", 64'(bus.rd_ready), 64'(1));
      rst_n = 1'b1;
      @(negedge clk);

      do_idcode();

      do_write(32'hDEADBEEF);
      do_write($urandom);
      chk("ovf_set", 64'(ir_out[2]), 64'(1));
      ir_scan(IR_CLEAR);
      chk("ovf_clear", 64'(ir_out[2]), 64'(0));
      chk_status("clear_status");
      do_ack();

      do_load(32'h12345678);
      chk("rd_ready_full", 64'(bus.rd_ready), 64'(0));
      do_read_scan();
      do_read_scan();

      do_bypass(8'b1011_0001);

      repeat (24) begin
         case ($urandom_range(0, 5))
            0: begin
               do_write($urandom);
               if ($urandom_range(0, 1) == 1)
                  do_ack();
            end
            1: do_load($urandom);
            2: do_read_scan();
            3: do_idcode();
            4: do_bypass(8'($urandom_range(0, 255)));
            default: begin
               ir_scan(IR_CLEAR);
               chk_status("rnd_clear");
            end
         endcase
      end

      // reset in the middle of a WRITE shift with a word pending
      if (!m_pend)
         do_write($urandom);
      ir_scan(IR_WRITE);
      tck_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o);
      for (int k = 0; k < 10; k++)
         tck_cycle(1'b0, 1'b1, 1'b0, 1'b0, k[0], o);
      cdr = 1'b0; sdr = 1'b0; udr = 1'b0; uir = 1'b0;
      rst_n = 1'b0;
      #20;
      chk("mid_rst_wr_valid", 64'(bus.wr_valid), 64'(0));
      chk("mid_rst_tdo", 64'(tdo), 64'(0));
      chk("mid_rst_ir_out", 64'(ir_out), 64'(0));
      m_hold_full = 1'b0; m_pend = 1'b0;
      m_ovf = 1'b0; m_perr = 1'b0; m_wdata = '0;
      rst_n = 1'b1;
      #20;
      do_write(32'hC0FFEE42);

`ifdef VJTAG_RESP_PARITY_EN
      do_ack();
      ir_scan(IR_WRITE);
      dr_scan({1'b0, 32'h1}, SR_W, 1'b1, dout);
      m_perr = 1'b1;
      chk("par_bad_wr_valid", 64'(bus.wr_valid), 64'(0));
      chk("par_bad_flag", 64'(ir_out[3]), 64'(1));
      chk_status("par_bad_status");
      dr_scan({1'b1, 32'h1}, SR_W, 1'b1, dout);
      m_pend = 1'b1;
      m_wdata = 32'h1;
      chk("par_ok_wr_valid", 64'(bus.wr_valid), 64'(1));
      chk("par_ok_wr_data", 64'(bus.wr_data), 64'(m_wdata));
      chk_status("par_ok_status");
`endif

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
